// File: rtl/index_handler_multi_if.sv
// Bus bundle for index_handler_multi: per-drive index inputs, clears,
// classification windows, timeout and all per-drive status outputs.
interface index_handler_multi_if #(
  parameter int NUM_DRIVES = 4,
  parameter int TIMER_W    = 32,
  parameter int CNT_W      = 16
);
  logic [NUM_DRIVES-1:0]         index_in;
  logic [NUM_DRIVES-1:0]         clear;
  logic [TIMER_W-1:0]            win_300_min;
  logic [TIMER_W-1:0]            win_300_max;
  logic [TIMER_W-1:0]            win_360_min;
  logic [TIMER_W-1:0]            win_360_max;
  logic [TIMER_W-1:0]            timeout_cycles;
  logic [NUM_DRIVES-1:0]         index_pulse;
  logic [NUM_DRIVES*TIMER_W-1:0] rev_time;
  logic [NUM_DRIVES*TIMER_W-1:0] rev_avg;
  logic [NUM_DRIVES*CNT_W-1:0]   rev_count;
  logic [NUM_DRIVES-1:0]         rpm_300;
  logic [NUM_DRIVES-1:0]         rpm_360;
  logic [NUM_DRIVES-1:0]         rpm_valid;
  logic [NUM_DRIVES-1:0]         index_timeout;

  modport master (
    output index_in, clear, win_300_min, win_300_max, win_360_min, win_360_max, timeout_cycles,
    input  index_pulse, rev_time, rev_avg, rev_count, rpm_300, rpm_360, rpm_valid, index_timeout
  );

  modport slave (
    input  index_in, clear, win_300_min, win_300_max, win_360_min, win_360_max, timeout_cycles,
    output index_pulse, rev_time, rev_avg, rev_count, rpm_300, rpm_360, rpm_valid, index_timeout
  );
endinterface

// File: rtl/index_handler_multi.sv
// Multi-drive floppy index handler: per drive a synchronizer, debounce
// filter, revolution timer FSM and 300/360 RPM classifier.
// Optional feature macro INDEX_AVG_EN: classify on the mean of the last
// four published periods instead of the latest one.
module index_handler_multi #(
  parameter int NUM_DRIVES   = 4,
  parameter int TIMER_W      = 32,
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  index_handler_multi_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_FIRST = 2'd0,
    TIMING     = 2'd1,
    STALLED    = 2'd2
  } state_t;

  localparam logic [7:0]         DB_MAX    = 8'(DEBOUNCE_CYC);
  localparam logic [TIMER_W-1:0] TIMER_ONE = TIMER_W'(1'b1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1'b1);

  for (genvar i = 0; i < NUM_DRIVES; i++) begin : g_drive
    logic               sync1_r, sync2_r, filt_r;
    logic [7:0]         db_cnt_r;
    logic               edge_s;
    state_t             state_r;
    logic [TIMER_W-1:0] timer_r, rev_time_r, period_s, rev_avg_s;
    logic [CNT_W-1:0]   rev_count_r;
    logic               pulse_r, cls_pend_r;
    logic               rpm_300_r, rpm_360_r, rpm_valid_r, timeout_r;
    logic               in_300_s, in_360_s, avg_ready_s;

    // An edge is accepted once the synchronized level has stayed high
    // DEBOUNCE_CYC cycles and has not yet been reported.
    assign edge_s   = (db_cnt_r == DB_MAX) && !filt_r;
    // Cycles between the previous pulse and this one (timer restarts at 0).
    assign period_s = (timer_r == '1) ? timer_r : timer_r + TIMER_ONE;
    assign in_300_s = (rev_avg_s >= bus.win_300_min) && (rev_avg_s <= bus.win_300_max);
    assign in_360_s = (rev_avg_s >= bus.win_360_min) && (rev_avg_s <= bus.win_360_max);

`ifdef INDEX_AVG_EN
    logic [TIMER_W-1:0] hist_r [4];
    logic [2:0]         hist_cnt_r;
    logic [TIMER_W+1:0] sum_s;

    // Mean of the four most recent periods once the history is full.
    always_comb begin
      sum_s = {2'b00, hist_r[0]} + {2'b00, hist_r[1]} + {2'b00, hist_r[2]} + {2'b00, hist_r[3]};
      if (hist_cnt_r == 3'd4) begin
        rev_avg_s   = sum_s[TIMER_W+1:2];
        avg_ready_s = 1'b1;
      end else begin
        rev_avg_s   = rev_time_r;
        avg_ready_s = 1'b0;
      end
    end
`else
    assign rev_avg_s   = rev_time_r;
    assign avg_ready_s = 1'b1;
`endif

    // Two-flop synchronizer followed by the consecutive-high debounce counter.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync1_r  <= 1'b0;
        sync2_r  <= 1'b0;
        db_cnt_r <= 8'd0;
        filt_r   <= 1'b0;
      end else begin
        sync1_r <= bus.index_in[i];
        sync2_r <= sync1_r;
        if (!sync2_r) begin
          db_cnt_r <= 8'd0;
          filt_r   <= 1'b0;
        end else begin
          if (db_cnt_r != DB_MAX) db_cnt_r <= db_cnt_r + 8'd1;
          if (edge_s) filt_r <= 1'b1;
        end
      end
    end

    // Revolution FSM: timing, statistics, timeout and delayed classification.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_r     <= WAIT_FIRST;
        timer_r     <= '0;
        rev_time_r  <= '0;
        rev_count_r <= '0;
        pulse_r     <= 1'b0;
        cls_pend_r  <= 1'b0;
        rpm_300_r   <= 1'b0;
        rpm_360_r   <= 1'b0;
        rpm_valid_r <= 1'b0;
        timeout_r   <= 1'b0;
`ifdef INDEX_AVG_EN
        for (int k = 0; k < 4; k++) hist_r[k] <= '0;
        hist_cnt_r <= 3'd0;
`endif
      end else begin
        // The strobe is reported even when a clear discards the edge.
        pulse_r    <= edge_s;
        cls_pend_r <= 1'b0;
        if (bus.clear[i]) begin
          state_r     <= WAIT_FIRST;
          timer_r     <= '0;
          rev_time_r  <= '0;
          rev_count_r <= '0;
          rpm_300_r   <= 1'b0;
          rpm_360_r   <= 1'b0;
          rpm_valid_r <= 1'b0;
          timeout_r   <= 1'b0;
`ifdef INDEX_AVG_EN
          hist_cnt_r <= 3'd0;
`endif
        end else begin
          // Status follows the period published one cycle earlier.
          if (cls_pend_r) begin
            if (avg_ready_s && in_300_s) begin
              rpm_300_r <= 1'b1; rpm_360_r <= 1'b0; rpm_valid_r <= 1'b1;
            end else if (avg_ready_s && in_360_s) begin
              rpm_300_r <= 1'b0; rpm_360_r <= 1'b1; rpm_valid_r <= 1'b1;
            end else begin
              rpm_300_r <= 1'b0; rpm_360_r <= 1'b0; rpm_valid_r <= 1'b0;
            end
          end
          case (state_r)
            WAIT_FIRST: begin
              if (edge_s) begin
                state_r     <= TIMING;
                timer_r     <= '0;
                rev_count_r <= rev_count_r + CNT_ONE;
              end
            end
            TIMING: begin
              if (edge_s) begin
                rev_time_r  <= period_s;
                rev_count_r <= rev_count_r + CNT_ONE;
                timer_r     <= '0;
                cls_pend_r  <= 1'b1;
`ifdef INDEX_AVG_EN
                hist_r[3]  <= hist_r[2];
                hist_r[2]  <= hist_r[1];
                hist_r[1]  <= hist_r[0];
                hist_r[0]  <= period_s;
                hist_cnt_r <= (hist_cnt_r == 3'd4) ? 3'd4 : hist_cnt_r + 3'd1;
`endif
              end else if ((bus.timeout_cycles != '0) && (timer_r >= bus.timeout_cycles)) begin
                state_r     <= STALLED;
                timeout_r   <= 1'b1;
                rpm_300_r   <= 1'b0;
                rpm_360_r   <= 1'b0;
                rpm_valid_r <= 1'b0;
              end else if (timer_r != '1) begin
                timer_r <= timer_r + TIMER_ONE;
              end
            end
            STALLED: begin
              if (edge_s) begin
                state_r     <= TIMING;
                timeout_r   <= 1'b0;
                timer_r     <= '0;
                rev_count_r <= rev_count_r + CNT_ONE;
`ifdef INDEX_AVG_EN
                hist_cnt_r <= 3'd0;
`endif
              end
            end
            default: state_r <= WAIT_FIRST;
          endcase
        end
      end
    end

    assign bus.index_pulse[i]                  = pulse_r;
    assign bus.rev_time[i*TIMER_W +: TIMER_W]  = rev_time_r;
    assign bus.rev_avg[i*TIMER_W +: TIMER_W]   = rev_avg_s;
    assign bus.rev_count[i*CNT_W +: CNT_W]     = rev_count_r;
    assign bus.rpm_300[i]                      = rpm_300_r;
    assign bus.rpm_360[i]                      = rpm_360_r;
    assign bus.rpm_valid[i]                    = rpm_valid_r;
    assign bus.index_timeout[i]                = timeout_r;
  end

endmodule

// File: tb/tb_index_handler_multi.sv
// Randomized bench for index_handler_multi against an event-level model:
// pulses are predicted from the high-run lengths driven, periods from pulse
// timestamps, classification from the window rules.
module tb_index_handler_multi;
  localparam int     ND = 4;
  localparam int     TW = 32;
  localparam int     CW = 16;
  localparam int     DB = 8;
  localparam longint TMAX = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  index_handler_multi_if #(.NUM_DRIVES(ND), .TIMER_W(TW), .CNT_W(CW)) bus ();

  index_handler_multi #(.NUM_DRIVES(ND), .TIMER_W(TW), .CNT_W(CW), .DEBOUNCE_CYC(DB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Stimulus bookkeeping
  longint cyc = 0;
  bit [ND-1:0] pend_pulse [longint];
  int  hi_left [ND];
  int  lo_left [ND];
  bit  auto_run [ND];
  int  fix_len [ND];
  int  fix_gap [ND];
  longint w3min = 250, w3max = 320, w6min = 200, w6max = 280, tmo = 0;

  // Reference model (0 = waiting for first edge, 1 = timing, 2 = stalled)
  int     m_state [ND];
  longint m_last [ND], m_time [ND], m_count [ND];
  longint m_hist [ND][4];
  int     m_hn [ND];
  bit     m_pulse [ND], m_300 [ND], m_360 [ND], m_valid [ND], m_to [ND], m_pend [ND];

  always_comb begin
    bus.win_300_min    = w3min[TW-1:0];
    bus.win_300_max    = w3max[TW-1:0];
    bus.win_360_min    = w6min[TW-1:0];
    bus.win_360_max    = w6max[TW-1:0];
    bus.timeout_cycles = tmo[TW-1:0];
  end

  function automatic longint exp_avg(int d);
`ifdef INDEX_AVG_EN
    if (m_hn[d] == 4) return (m_hist[d][0] + m_hist[d][1] + m_hist[d][2] + m_hist[d][3]) / 4;
`endif
    return m_time[d];
  endfunction

  function automatic void classify(int d);
    longint a = exp_avg(d);
    bit ready = 1'b1;
`ifdef INDEX_AVG_EN
    ready = (m_hn[d] == 4);
`endif
    m_300[d] = 1'b0; m_360[d] = 1'b0; m_valid[d] = 1'b0;
    if (ready && a >= w3min && a <= w3max) begin
      m_300[d] = 1'b1; m_valid[d] = 1'b1;
    end else if (ready && a >= w6min && a <= w6max) begin
      m_360[d] = 1'b1; m_valid[d] = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < ND; d++) begin
      m_state[d] = 0; m_last[d] = 0; m_time[d] = 0; m_count[d] = 0; m_hn[d] = 0;
      m_pulse[d] = 0; m_300[d] = 0; m_360[d] = 0; m_valid[d] = 0; m_to[d] = 0; m_pend[d] = 0;
      hi_left[d] = 0; lo_left[d] = 0; auto_run[d] = 0;
    end
    pend_pulse.delete();
  endfunction

  function automatic void model_step(longint k, bit [ND-1:0] clr);
    bit [ND-1:0] pv = '0;
    if (pend_pulse.exists(k)) begin
      pv = pend_pulse[k];
      pend_pulse.delete(k);
    end
    for (int d = 0; d < ND; d++) begin
      m_pulse[d] = pv[d];
      if (clr[d]) begin
        m_state[d] = 0; m_time[d] = 0; m_count[d] = 0; m_hn[d] = 0;
        m_300[d] = 0; m_360[d] = 0; m_valid[d] = 0; m_to[d] = 0; m_pend[d] = 0;
      end else begin
        if (m_pend[d]) classify(d);
        m_pend[d] = 0;
        if (pv[d]) begin
          if (m_state[d] == 1) begin
            m_time[d] = (k - m_last[d] > TMAX) ? TMAX : k - m_last[d];
            for (int h = 3; h > 0; h--) m_hist[d][h] = m_hist[d][h-1];
            m_hist[d][0] = m_time[d];
            if (m_hn[d] < 4) m_hn[d]++;
            m_pend[d] = 1;
          end else if (m_state[d] == 2) begin
            m_to[d] = 0;
            m_hn[d] = 0;
          end
          m_state[d] = 1;
          m_count[d] = (m_count[d] + 1) % 65536;
          m_last[d]  = k;
        end else if (m_state[d] == 1 && tmo != 0 && (k - 1 - m_last[d]) >= tmo) begin
          m_state[d] = 2; m_to[d] = 1; m_300[d] = 0; m_360[d] = 0; m_valid[d] = 0;
        end
      end
    end
  endfunction

  // Schedule a high run of len cycles then gap low cycles, starting at the next edge.
  function automatic void queue_run(int d, int len, int gap);
    bit [ND-1:0] t;
    longint key = cyc + 1 + 2 + DB;
    hi_left[d] = len;
    lo_left[d] = gap;
    if (len >= DB) begin
      t = pend_pulse.exists(key) ? pend_pulse[key] : '0;
      t[d] = 1'b1;
      pend_pulse[key] = t;
    end
  endfunction

  task automatic compare_all();
    for (int d = 0; d < ND; d++) begin
      check_eq($sformatf("pulse%0d", d),   bus.index_pulse[d], m_pulse[d]);
      check_eq($sformatf("time%0d", d),    bus.rev_time[d*TW +: TW], m_time[d]);
      check_eq($sformatf("avg%0d", d),     bus.rev_avg[d*TW +: TW], exp_avg(d));
      check_eq($sformatf("count%0d", d),   bus.rev_count[d*CW +: CW], m_count[d]);
      check_eq($sformatf("r300_%0d", d),   bus.rpm_300[d], m_300[d]);
      check_eq($sformatf("r360_%0d", d),   bus.rpm_360[d], m_360[d]);
      check_eq($sformatf("valid%0d", d),   bus.rpm_valid[d], m_valid[d]);
      check_eq($sformatf("timeout%0d", d), bus.index_timeout[d], m_to[d]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulse"}, bus.index_pulse, 0);
    check_eq({tag, "_time"},  bus.rev_time, 0);
    check_eq({tag, "_avg"},   bus.rev_avg, 0);
    check_eq({tag, "_count"}, bus.rev_count, 0);
    check_eq({tag, "_stat"},  {bus.rpm_300, bus.rpm_360, bus.rpm_valid, bus.index_timeout}, 0);
  endtask

  // One clock: drive inputs, step the model at the edge, compare #1 later.
  task automatic tick(input logic [ND-1:0] clr);
    logic [ND-1:0] v;
    for (int d = 0; d < ND; d++) begin
      if (hi_left[d] == 0 && lo_left[d] == 0 && auto_run[d])
        queue_run(d, (fix_len[d] != 0) ? fix_len[d] : int'($urandom_range(14, 1)),
                     (fix_gap[d] != 0) ? fix_gap[d] : int'($urandom_range(330, 150)));
      if (hi_left[d] > 0) begin
        v[d] = 1'b1;
        hi_left[d]--;
      end else begin
        v[d] = 1'b0;
        if (lo_left[d] > 0) lo_left[d]--;
      end
    end
    bus.index_in = v;
    bus.clear    = clr;
    @(posedge clk);
    cyc++;
    model_step(cyc, clr);
    #1;
    compare_all();
  endtask

  // Asynchronous reset between edges; outputs must drop without a clock.
  task automatic pulse_reset(input string tag);
    bus.index_in = '0;
    bus.clear    = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero(tag);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [ND-1:0] clr;
    longint pcyc;
    for (int d = 0; d < ND; d++) begin
      fix_len[d] = 0;
      fix_gap[d] = 0;
    end
    model_reset();
    bus.index_in = '0;
    bus.clear    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Short glitch on drive 1 must leave no trace.
    queue_run(1, 5, 30);
    repeat (40) tick('0);
    check_eq("glitch_count1", bus.rev_count[1*CW +: CW], 0);

    // All drives edge together at a 220-cycle period (360 RPM window).
    for (int d = 0; d < ND; d++) begin
      auto_run[d] = 1'b1; fix_len[d] = 10; fix_gap[d] = 210;
    end
    repeat (6 * 220 + 20) tick('0);
    check_eq("sim_rpm360", bus.rpm_360, 4'hF);
    check_eq("sim_time0", bus.rev_time[0 +: TW], 220);
    for (int d = 0; d < ND; d++) begin
      auto_run[d] = 1'b0; fix_len[d] = 0; fix_gap[d] = 0;
    end
    repeat (100) tick('0);
    pulse_reset("midrev");

    // Timeout after a single edge, then recovery without a published period.
    tmo = 1000;
    queue_run(0, 10, 20);
    repeat (1300) tick('0);
    check_eq("stall_flag0", bus.index_timeout[0], 1);
    queue_run(0, 10, 20);
    repeat (40) tick('0);
    check_eq("recover_flag0", bus.index_timeout[0], 0);
    check_eq("recover_time0", bus.rev_time[0 +: TW], 0);
    tmo = 0;

    // Clear coincident with an accepted edge on drive 2.
    queue_run(2, 10, 50);
    repeat (70) tick('0);
    queue_run(2, 10, 50);
    pcyc = cyc + 1 + 2 + DB;
    while (cyc + 1 < pcyc) tick('0);
    tick(4'b0100);
    check_eq("clr_pulse2", bus.index_pulse[2], 1);
    check_eq("clr_count2", bus.rev_count[2*CW +: CW], 0);
    repeat (60) tick('0);

    // Random run lengths, gaps and clears; second half with a timeout.
    for (int d = 0; d < ND; d++) auto_run[d] = 1'b1;
    for (int ph = 0; ph < 2; ph++) begin
      tmo = (ph == 0) ? 0 : 600;
      for (int n = 0; n < 12000; n++) begin
        for (int d = 0; d < ND; d++) clr[d] = ($urandom_range(299, 0) == 0);
        tick(clr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
